// File: rtl/umul_array.sv
// rtl/umul_array.sv - array of stochastic-by-binary multipliers driven by a bit-reversed counter RNG
// Optional per-channel period ones counter (cnt port) is compiled in with UMUL_ARRAY_CNT_EN.
module umul_array #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [CH-1:0]             iA,
  input  logic [CH*WIDTH-1:0]       iB,
  input  logic [CH-1:0]             loadB,
  input  logic                      bipolar,
  output logic [CH-1:0]             oC,
  output logic                      period_done
`ifdef UMUL_ARRAY_CNT_EN
  ,
  output logic [CH*(WIDTH+1)-1:0]   cnt
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else begin
      pc <= pc + ONE;
    end
  end

  // A restart in the last cycle of a period must not report a completed period.
  assign period_done = rst_n & ~clr & (pc == '1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [WIDTH-1:0] bbuf;
    logic [WIDTH-1:0] cp;
    logic [WIDTH-1:0] cn;
    logic [WIDTH-1:0] rp;
    logic [WIDTH-1:0] rn;
    logic             gt_p;
    logic             gt_n;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bbuf <= '0;
      end else if (loadB[i]) begin
        bbuf <= iB[i*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cp <= '0;
        cn <= '0;
      end else if (clr) begin
        cp <= '0;
        cn <= '0;
      end else begin
        if (iA[i]) begin
          cp <= cp + ONE;
        end
        if (!iA[i] && bipolar) begin
          cn <= cn + ONE;
        end
      end
    end

    // Bit reversal of a binary count yields the van der Corput sequence.
    for (genvar k = 0; k < WIDTH; k++) begin : g_rev
      assign rp[k] = cp[WIDTH-1-k];
      assign rn[k] = cn[WIDTH-1-k];
    end

    assign gt_p = (bbuf > rp);
    assign gt_n = (bbuf > rn);

    assign oC[i] = rst_n & (bipolar ? (iA[i] ? gt_p : ~gt_n) : (iA[i] & gt_p));

`ifdef UMUL_ARRAY_CNT_EN
    logic [WIDTH:0] acc;
    logic [WIDTH:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc   <= '0;
        cnt_q <= '0;
      end else if (clr) begin
        acc <= '0;
      end else if (period_done) begin
        cnt_q <= acc + (WIDTH+1)'(oC[i]);
        acc   <= '0;
      end else begin
        acc <= acc + (WIDTH+1)'(oC[i]);
      end
    end

    assign cnt[i*(WIDTH+1) +: WIDTH+1] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_umul_array.sv
// tb/tb_umul_array.sv - self-checking bench for umul_array against a behavioural model
// Checks cnt only when UMUL_ARRAY_CNT_EN is defined.
module tb_umul_array;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int N  = 1 << W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            bipolar = 1'b0;
  logic [CH-1:0]   iA = '0;
  logic [CH-1:0]   loadB = '0;
  logic [CH*W-1:0] iB = '0;
  logic [CH-1:0]   oC;
  logic            period_done;
`ifdef UMUL_ARRAY_CNT_EN
  logic [CH*(W+1)-1:0] cnt;
`endif

  int errors = 0;
  int checks = 0;
  int bbuf_m[CH];
  int cp_m[CH];
  int cn_m[CH];
  int acc_m[CH];
  int cnt_m[CH];
  int pc_m;
  int ones[CH];
  int gap;

  umul_array #(.WIDTH(W), .CH(CH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .iA(iA),
    .iB(iB),
    .loadB(loadB),
    .bipolar(bipolar),
    .oC(oC),
    .period_done(period_done)
`ifdef UMUL_ARRAY_CNT_EN
    ,
    .cnt(cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bitrev(int v);
    int r = 0;
    for (int k = 0; k < W; k++) if (v[k]) r |= 1 << (W - 1 - k);
    return r;
  endfunction

  function automatic bit exp_oc(int c);
    int b = bbuf_m[c];
    if (!rst_n) return 1'b0;
    if (bipolar) return iA[c] ? (b > bitrev(cp_m[c])) : !(b > bitrev(cn_m[c]));
    return iA[c] && (b > bitrev(cp_m[c]));
  endfunction

  function automatic bit exp_pd();
    return rst_n && !clr && (pc_m == N - 1);
  endfunction

  // Reference model of the architectural state
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_m <= 0;
      for (int c = 0; c < CH; c++) begin
        bbuf_m[c] <= 0;
        cp_m[c]   <= 0;
        cn_m[c]   <= 0;
        acc_m[c]  <= 0;
        cnt_m[c]  <= 0;
      end
    end else begin
      pc_m <= clr ? 0 : (pc_m + 1) % N;
      for (int c = 0; c < CH; c++) begin
        if (loadB[c]) bbuf_m[c] <= int'(iB[c*W +: W]);
        if (clr) begin
          cp_m[c]  <= 0;
          cn_m[c]  <= 0;
          acc_m[c] <= 0;
        end else begin
          if (iA[c]) cp_m[c] <= (cp_m[c] + 1) % N;
          if (!iA[c] && bipolar) cn_m[c] <= (cn_m[c] + 1) % N;
          if (exp_pd()) begin
            cnt_m[c] <= acc_m[c] + int'(exp_oc(c));
            acc_m[c] <= 0;
          end else begin
            acc_m[c] <= acc_m[c] + int'(exp_oc(c));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("period_done", int'(period_done), int'(exp_pd()));
    for (int c = 0; c < CH; c++) begin
      check($sformatf("oC[%0d]", c), int'(oC[c]), int'(exp_oc(c)));
`ifdef UMUL_ARRAY_CNT_EN
      check($sformatf("cnt[%0d]", c), int'(cnt[c*(W+1) +: W+1]), cnt_m[c]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_b(int c, int v);
    iB[c*W +: W] = v[W-1:0];
  endtask

  task automatic load_clr(int b0, int b1, int b2, int b3);
    set_b(0, b0);
    set_b(1, b1);
    set_b(2, b2);
    set_b(3, b3);
    loadB = '1;
    clr   = 1'b1;
    tick();
    loadB = '0;
    clr   = 1'b0;
  endtask

  task automatic run_period(logic [CH-1:0] a_mask, bit alt, int ld_cyc, int ld_ch, int ld_val);
    for (int c = 0; c < CH; c++) ones[c] = 0;
    for (int n = 0; n < N; n++) begin
      iA    = (alt && (n % 2 == 1)) ? '0 : a_mask;
      loadB = '0;
      if (n == ld_cyc) begin
        set_b(ld_ch, ld_val);
        loadB[ld_ch] = 1'b1;
      end
      @(negedge clk);
      for (int c = 0; c < CH; c++) ones[c] += int'(oC[c]);
      if (n == N - 1) check("pd_at_period_end", int'(period_done), 1);
      tick();
    end
    loadB = '0;
  endtask

  task automatic check_ones(string name, int e0, int e1, int e2, int e3);
    int e[CH];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    e[3] = e3;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("%s_ones[%0d]", name, c), ones[c], e[c]);
`ifdef UMUL_ARRAY_CNT_EN
      check($sformatf("%s_cnt[%0d]", name, c), int'(cnt[c*(W+1) +: W+1]), e[c]);
`endif
    end
  endtask

  initial begin
    iA = '1;
    repeat (3) tick();
    check("reset_oC", int'(oC), 0);
    check("reset_pd", int'(period_done), 0);
    rst_n = 1'b1;
    tick();

    // Unipolar, iA constant 1, load coinciding with restart
    iA = '1;
    load_clr(128, 0, 255, 64);
    run_period('1, 1'b0, -1, 0, 0);
    check_ones("uni", 128, 0, 255, 64);

    // Unipolar, alternating iA
    load_clr(192, 192, 192, 192);
    run_period('1, 1'b1, -1, 0, 0);
    check_ones("alt", 96, 96, 96, 96);

    // Bipolar: iA=1 on channels 0/2, iA=0 on channels 1/3
    bipolar = 1'b1;
    load_clr(128, 255, 128, 0);
    run_period(4'b0101, 1'b0, -1, 0, 0);
    check_ones("bip", 128, 1, 128, 256);
    bipolar = 1'b0;

    // Load path: channel 2 switches from 64 to 200 after cycle 10
    iA = '1;
    load_clr(64, 64, 64, 64);
    run_period('1, 1'b0, 10, 2, 200);
    check_ones("load", 64, 64, 193, 64);

    // Restart mid-period
    load_clr(128, 128, 128, 128);
    repeat (100) tick();
    clr = 1'b1;
    @(negedge clk);
    check("pd_on_clr_mid", int'(period_done), 0);
    tick();
    clr = 1'b0;
    gap = 0;
    for (int c = 0; c < CH; c++) ones[c] = 0;
    while (1) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) ones[c] += int'(oC[c]);
      if (period_done || gap >= 400) break;
      gap++;
      tick();
    end
    tick();
    check("restart_gap", gap, 255);
    check_ones("restart", 128, 128, 128, 128);

    // Restart exactly in the period_done cycle suppresses the pulse
    repeat (N - 1) tick();
    clr = 1'b1;
    @(negedge clk);
    check("pd_on_clr_last", int'(period_done), 0);
    tick();
    clr = 1'b0;

    // Reset mid-period
    load_clr(100, 100, 100, 100);
    repeat (50) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_oC", int'(oC), 0);
    check("rst_mid_pd", int'(period_done), 0);
`ifdef UMUL_ARRAY_CNT_EN
    check("rst_mid_cnt", int'(cnt), 0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    run_period('1, 1'b0, -1, 0, 0);
    check_ones("post_rst", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/umul_array.md
UMUL_ARRAY -- requirements
Module: umul_array

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/RNG width in bits, legal range 2..16.
REQ-002 SHALL have parameter CH, default 4: number of independent multiplier channels, legal range 1..32.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous restart of RNG and period state.
REQ-006 SHALL have port iA  input  CH  stochastic bitstream per channel.
REQ-007 SHALL have port iB  input  CH*WIDTH  binary operand per channel; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port loadB  input  CH  per-channel operand load strobe.
REQ-009 SHALL have port bipolar  input  1  mode select: 0 unipolar, 1 bipolar.
REQ-010 SHALL have port oC  output  CH  product bitstream per channel.
REQ-011 SHALL have port period_done  output  1  one-cycle pulse at the end of each 2^WIDTH-cycle period.
REQ-012 SHALL have port cnt  output  CH*(WIDTH+1)  per-channel ones count of the last completed period; present only with UMUL_ARRAY_CNT_EN.

Function
REQ-013 SHALL hold per channel a WIDTH-bit register bbuf[i], loaded from iB[i] at an edge where loadB[i]=1 and otherwise held; the new value affects oC from the following cycle.
REQ-014 SHALL hold per channel two WIDTH-bit counters cp[i] and cn[i], wrapping modulo 2^WIDTH.
REQ-015 SHALL increment cp[i] at every edge where iA[i]=1, and cn[i] at every edge where iA[i]=0 and bipolar=1.
REQ-016 SHALL form RNG values rp[i]=bitreverse(cp[i]) and rn[i]=bitreverse(cn[i]), i.e. a 1-D Sobol/van der Corput sequence.
REQ-017 SHALL, in unipolar mode, drive oC[i] = iA[i] AND (bbuf[i] > rp[i]), combinational, zero latency from iA.
REQ-018 SHALL, in bipolar mode, drive oC[i] = (bbuf[i] > rp[i]) when iA[i]=1, and NOT(bbuf[i] > rn[i]) when iA[i]=0, with bbuf as an offset-binary value.
REQ-019 SHALL keep a shared WIDTH-bit period counter pc that increments every cycle and wraps.
REQ-020 SHALL assert period_done for exactly the cycle in which pc = 2^WIDTH-1.
REQ-021 SHALL, on clr=1, set cp, cn and pc to 0 at that edge, leave bbuf untouched, and suppress period_done in that cycle.
REQ-022 SHALL, when clr and loadB[i] coincide, perform both actions at the same edge.
REQ-023 SHALL treat a change of bipolar mid-period as legal, with no counter reset; results for that period are undefined.

Reset
REQ-024 SHALL, while rst_n=0, clear bbuf, cp, cn, pc and all count registers to 0, and hold period_done=0.
REQ-025 SHALL drive oC=0 in reset for all channels, and cnt=0 when present.
REQ-026 SHALL start the first period in the first cycle after rst_n deasserts; reset asserted mid-period SHALL abandon that period with no period_done pulse.

Configuration
REQ-027 SHALL compile in, under macro UMUL_ARRAY_CNT_EN, a per-channel WIDTH+1-bit accumulator counting oC[i]=1 cycles in the current period.
REQ-028 SHALL, with UMUL_ARRAY_CNT_EN defined, copy accumulator+oC[i] into cnt[i] at the period_done edge, restart the accumulator at 0, zero it on clr, and otherwise hold cnt.
REQ-029 SHALL, without UMUL_ARRAY_CNT_EN, omit the cnt port and the accumulators; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover (WIDTH=8, unipolar, iA=1 constant): B=128 -> exactly 128 oC ones per 256 cycles, cnt=128; B=0 -> cnt=0; B=255 -> cnt=255.
REQ-031 SHALL cover (unipolar): iA alternating 1,0, B=192 -> cnt=96 after the first period_done.
REQ-032 SHALL cover (bipolar): iA=1 constant with B=128 -> cnt=128; iA=0 constant with B=255 -> cnt=1.
REQ-033 SHALL cover the load path: loadB[2] pulse at cycle 10 with B 64->200 -> oC[2] uses 200 from cycle 11, and other channels are unaffected.
REQ-034 SHALL cover restart: clr at cycle 100 -> no period_done in that cycle, next period_done 255 cycles later, cnt from a fresh count.
REQ-035 SHALL cover reset: rst_n low mid-period -> oC=0, cnt=0, period_done=0 immediately, bbuf=0 after release.
